// File: rtl/cl_pattern_pkg.sv
// Shared encodings for the Camera Link pattern generator: FSM states and pattern codes.
package cl_pattern_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FV_SETUP,
        ST_LINE,
        ST_LINE_BLANK,
        ST_FV_HOLD,
        ST_FRAME_BLANK
    } state_t;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CONST = 2'd2;
    localparam logic [1:0] PAT_MOVE  = 2'd3;

endpackage

// File: rtl/cl_pattern_data.sv
// Registered pixel-pair generator; takes next-cycle coordinates so its output lines up with the valids.
module cl_pattern_data #(
    parameter int PIXEL_WIDTH = 8,
    parameter int PARAM_WIDTH = 12,
    parameter int FCNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             pattern,
    input  logic [PARAM_WIDTH-1:0] x,
    input  logic [PARAM_WIDTH-1:0] y,
    input  logic [FCNT_WIDTH-1:0]  f,
    input  logic [PIXEL_WIDTH-1:0] cst,
    input  logic                   active,
    output logic [PIXEL_WIDTH-1:0] data_l,
    output logic [PIXEL_WIDTH-1:0] data_r
);
    import cl_pattern_pkg::*;

    logic [PIXEL_WIDTH-1:0] x2, fp, l_d, r_d;

    // Even tap index truncated to pixel width; odd tap is always one above it.
    assign x2 = PIXEL_WIDTH'({x, 1'b0});
    assign fp = PIXEL_WIDTH'(f);

    always_comb begin
        l_d = '0;
        r_d = '0;
        if (active) begin
            case (pattern)
                PAT_HRAMP: begin
                    l_d = x2;
                    r_d = x2 + 1'b1;
                end
                PAT_VRAMP: begin
                    l_d = PIXEL_WIDTH'(y);
                    r_d = PIXEL_WIDTH'(y);
                end
                PAT_CONST: begin
                    l_d = cst;
                    r_d = cst;
                end
                default: begin
                    l_d = x2 + fp;
                    r_d = x2 + 1'b1 + fp;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_l <= '0;
            data_r <= '0;
        end else begin
            data_l <= l_d;
            data_r <= r_d;
        end
    end

endmodule

// File: rtl/cl_pattern_gen.sv
// Camera Link base-configuration camera emulator: FVAL/LVAL/DVAL frame timing plus two test-pattern taps.
module cl_pattern_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int PARAM_WIDTH = 12,
    parameter int FCNT_WIDTH  = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   iENABLE,
    input  logic [1:0]             iPATTERN,
    input  logic [PIXEL_WIDTH-1:0] iCONST,
    input  logic [PARAM_WIDTH-1:0] iLINE_PIX,
    input  logic [PARAM_WIDTH-1:0] iLINE_BLANK,
    input  logic [PARAM_WIDTH-1:0] iVACT,
    input  logic [PARAM_WIDTH-1:0] iFV_SETUP,
    input  logic [PARAM_WIDTH-1:0] iFV_HOLD,
    input  logic [PARAM_WIDTH-1:0] iFRAME_BLANK,
    output logic                   oFVAL,
    output logic                   oLVAL,
    output logic                   oDVAL,
    output logic [PIXEL_WIDTH-1:0] oDATA_L,
    output logic [PIXEL_WIDTH-1:0] oDATA_R,
    output logic                   oFRAME_DONE,
    output logic [FCNT_WIDTH-1:0]  oFRAME_CNT,
    output logic                   oBUSY
);
    import cl_pattern_pkg::*;

    // Lengths are stored as (n-1) so a down-counter reaching zero marks the last cycle; 0 acts as 1.
    function automatic logic [PARAM_WIDTH-1:0] len_m1(input logic [PARAM_WIDTH-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    state_t                 state_q, state_d;
    logic [PARAM_WIDTH-1:0] cnt_q, cnt_d, x_q, x_d, y_q, y_d;
    logic [PARAM_WIDTH-1:0] lp_m1_q, lb_m1_q, vact_m1_q, hold_m1_q, fb_m1_q;
    logic [1:0]             pat_q;
    logic [PIXEL_WIDTH-1:0] cst_q;
    logic [FCNT_WIDTH-1:0]  fcnt_q;
    logic                   fval_q, lval_q, done_q, busy_q;
    logic                   latch, frame_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        x_d     = x_q;
        y_d     = y_q;
        latch   = 1'b0;
        case (state_q)
            ST_IDLE: if (iENABLE) begin
                state_d = ST_FV_SETUP;
                cnt_d   = len_m1(iFV_SETUP);
                latch   = 1'b1;
                x_d     = '0;
                y_d     = '0;
            end
            ST_FV_SETUP: if (cnt_q == '0) begin
                state_d = ST_LINE;
                cnt_d   = lp_m1_q;
                x_d     = '0;
            end
            ST_LINE: begin
                if (cnt_q == '0) begin
                    state_d = (y_q == vact_m1_q) ? ST_FV_HOLD : ST_LINE_BLANK;
                    cnt_d   = (y_q == vact_m1_q) ? hold_m1_q  : lb_m1_q;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            ST_LINE_BLANK: if (cnt_q == '0) begin
                state_d = ST_LINE;
                cnt_d   = lp_m1_q;
                x_d     = '0;
                y_d     = y_q + 1'b1;
            end
            ST_FV_HOLD: if (cnt_q == '0) begin
                state_d = ST_FRAME_BLANK;
                cnt_d   = fb_m1_q;
            end
            ST_FRAME_BLANK: if (cnt_q == '0) begin
                if (iENABLE) begin
                    state_d = ST_FV_SETUP;
                    cnt_d   = len_m1(iFV_SETUP);
                    latch   = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign frame_end = (state_d == ST_FRAME_BLANK) && (state_q != ST_FRAME_BLANK);

    // Outputs are registered from the next state so they change together with the state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            lp_m1_q   <= '0;
            lb_m1_q   <= '0;
            vact_m1_q <= '0;
            hold_m1_q <= '0;
            fb_m1_q   <= '0;
            pat_q     <= PAT_HRAMP;
            cst_q     <= '0;
            fcnt_q    <= '0;
            fval_q    <= 1'b0;
            lval_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (latch) begin
                lp_m1_q   <= len_m1(iLINE_PIX);
                lb_m1_q   <= len_m1(iLINE_BLANK);
                vact_m1_q <= len_m1(iVACT);
                hold_m1_q <= len_m1(iFV_HOLD);
                fb_m1_q   <= len_m1(iFRAME_BLANK);
                pat_q     <= iPATTERN;
                cst_q     <= iCONST;
            end
            fval_q <= (state_d == ST_FV_SETUP) || (state_d == ST_LINE) ||
                      (state_d == ST_LINE_BLANK) || (state_d == ST_FV_HOLD);
            lval_q <= (state_d == ST_LINE);
            busy_q <= (state_d != ST_IDLE);
            done_q <= frame_end;
            if (frame_end) fcnt_q <= fcnt_q + 1'b1;
        end
    end

    cl_pattern_data #(
        .PIXEL_WIDTH(PIXEL_WIDTH),
        .PARAM_WIDTH(PARAM_WIDTH),
        .FCNT_WIDTH (FCNT_WIDTH)
    ) u_data (
        .clk    (CLK),
        .rst_n  (RST_N),
        .pattern(pat_q),
        .x      (x_d),
        .y      (y_d),
        .f      (fcnt_q),
        .cst    (cst_q),
        .active (state_d == ST_LINE),
        .data_l (oDATA_L),
        .data_r (oDATA_R)
    );

    assign oFVAL       = fval_q;
    assign oLVAL       = lval_q;
    assign oDVAL       = lval_q;
    assign oFRAME_DONE = done_q;
    assign oFRAME_CNT  = fcnt_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_cl_pattern_gen.sv
// Scoreboard bench for cl_pattern_gen: a frame-level model queues expected per-cycle outputs, a monitor compares.
module tb_cl_pattern_gen;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        iENABLE = 1'b0;
    logic [1:0]  iPATTERN = '0;
    logic [7:0]  iCONST = '0;
    logic [11:0] iLINE_PIX = '0, iLINE_BLANK = '0, iVACT = '0;
    logic [11:0] iFV_SETUP = '0, iFV_HOLD = '0, iFRAME_BLANK = '0;
    logic        oFVAL, oLVAL, oDVAL, oFRAME_DONE, oBUSY;
    logic [7:0]  oDATA_L, oDATA_R, oFRAME_CNT;

    cl_pattern_gen #(.PIXEL_WIDTH(8), .PARAM_WIDTH(12), .FCNT_WIDTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .iENABLE(iENABLE), .iPATTERN(iPATTERN), .iCONST(iCONST),
        .iLINE_PIX(iLINE_PIX), .iLINE_BLANK(iLINE_BLANK), .iVACT(iVACT),
        .iFV_SETUP(iFV_SETUP), .iFV_HOLD(iFV_HOLD), .iFRAME_BLANK(iFRAME_BLANK),
        .oFVAL(oFVAL), .oLVAL(oLVAL), .oDVAL(oDVAL), .oDATA_L(oDATA_L), .oDATA_R(oDATA_R),
        .oFRAME_DONE(oFRAME_DONE), .oFRAME_CNT(oFRAME_CNT), .oBUSY(oBUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        bit       fval;
        bit       lval;
        bit       dval;
        bit [7:0] l;
        bit [7:0] r;
        bit       done;
        bit [7:0] fcnt;
        bit       busy;
    } exp_t;

    typedef struct {
        int setup, lp, lb, vact, hold, fb, pat, cst;
    } prm_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mf = 0;   // model frame counter

    function automatic int cl(int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int period(prm_t p);
        return cl(p.setup) + cl(p.vact) * cl(p.lp) + (cl(p.vact) - 1) * cl(p.lb) + cl(p.hold) + cl(p.fb);
    endfunction

    task automatic push(bit fv, bit lv, int l, int r, bit done, bit busy);
        exp_t e;
        e.fval = fv; e.lval = lv; e.dval = lv;
        e.l = l[7:0]; e.r = r[7:0];
        e.done = done; e.fcnt = mf[7:0]; e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic push_idle(int n);
        for (int i = 0; i < n; i++) push(0, 0, 0, 0, 0, 0);
    endtask

    // One whole frame derived straight from the timing and pattern definitions.
    task automatic push_frame(prm_t p);
        int l, r;
        for (int i = 0; i < cl(p.setup); i++) push(1, 0, 0, 0, 0, 1);
        for (int y = 0; y < cl(p.vact); y++) begin
            for (int x = 0; x < cl(p.lp); x++) begin
                case (p.pat)
                    0:       begin l = 2 * x;      r = 2 * x + 1;      end
                    1:       begin l = y;          r = y;              end
                    2:       begin l = p.cst;      r = p.cst;          end
                    default: begin l = 2 * x + mf; r = 2 * x + 1 + mf; end
                endcase
                push(1, 1, l % 256, r % 256, 0, 1);
            end
            if (y < cl(p.vact) - 1)
                for (int i = 0; i < cl(p.lb); i++) push(1, 0, 0, 0, 0, 1);
        end
        for (int i = 0; i < cl(p.hold); i++) push(1, 0, 0, 0, 0, 1);
        mf = (mf + 1) % 256;
        for (int i = 0; i < cl(p.fb); i++) push(0, 0, 0, 0, i == 0, 1);
    endtask

    task automatic drive(prm_t p);
        iFV_SETUP = 12'(p.setup); iLINE_PIX = 12'(p.lp); iLINE_BLANK = 12'(p.lb);
        iVACT = 12'(p.vact); iFV_HOLD = 12'(p.hold); iFRAME_BLANK = 12'(p.fb);
        iPATTERN = 2'(p.pat); iCONST = 8'(p.cst);
    endtask

    task automatic wait_drain();
        int budget = 5000;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge CLK);
            budget--;
        end
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d expected cycles left, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Called one time unit after a rising edge with the DUT idle. Enable drops drop_off cycles into the last frame.
    task automatic run_frames(prm_t p, int n, int drop_off, bit scramble);
        drive(p);
        iENABLE = 1'b1;
        push_idle(1);
        for (int k = 0; k < n; k++) push_frame(p);
        push_idle(4);
        repeat (1 + (n - 1) * period(p) + drop_off) @(posedge CLK);
        #1;
        iENABLE = 1'b0;
        if (scramble) begin
            iFV_SETUP = 12'($urandom_range(0, 9)); iLINE_PIX = 12'($urandom_range(0, 9));
            iLINE_BLANK = 12'($urandom_range(0, 9)); iVACT = 12'($urandom_range(0, 9));
            iFV_HOLD = 12'($urandom_range(0, 9)); iFRAME_BLANK = 12'($urandom_range(0, 9));
            iPATTERN = 2'($urandom_range(0, 3)); iCONST = 8'($urandom);
        end
        wait_drain();
    endtask

    task automatic check_zero(string name);
        logic [20:0] act;
        act = {oFVAL, oLVAL, oDVAL, oDATA_L, oDATA_R, oFRAME_DONE, oBUSY};
        checks++;
        if (act != '0 || oFRAME_CNT != 8'(mf)) begin
            errors++;
            $display("FAIL %s: outputs=%h fcnt=%0d, want outputs=0 fcnt=%0d", name, act, oFRAME_CNT, mf);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e, a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = '{oFVAL, oLVAL, oDVAL, oDATA_L, oDATA_R, oFRAME_DONE, oFRAME_CNT, oBUSY};
            checks++;
            if (a != e) begin
                errors++;
                $display("FAIL stream t=%0t got fv%0b lv%0b dv%0b L%0d R%0d dn%0b fc%0d bz%0b want fv%0b lv%0b dv%0b L%0d R%0d dn%0b fc%0d bz%0b",
                         $time, a.fval, a.lval, a.dval, a.l, a.r, a.done, a.fcnt, a.busy,
                         e.fval, e.lval, e.dval, e.l, e.r, e.done, e.fcnt, e.busy);
            end
        end
    end

    initial begin
        prm_t basic, p;
        basic = '{setup: 1, lp: 4, lb: 2, vact: 3, hold: 1, fb: 3, pat: 0, cst: 0};

        repeat (2) @(posedge CLK);
        #1;
        check_zero("reset_state");
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check_zero("idle_after_reset");

        // basic h-ramp frames, then v-ramp with identical timing
        run_frames(basic, 3, cl(basic.setup), 0);
        p = basic; p.pat = 1;
        run_frames(p, 2, cl(p.setup), 0);

        // enable dropped during line 1 while inputs are scrambled mid-frame
        p = basic; p.pat = 2; p.cst = 8'hA5;
        run_frames(p, 1, basic.setup + basic.lp + basic.lb + 1, 1);

        // all-zero timing with two lines
        p = '{setup: 0, lp: 0, lb: 0, vact: 2, hold: 0, fb: 0, pat: 2, cst: 8'h3C};
        run_frames(p, 2, 1, 0);

        // moving ramp long enough for the frame counter to wrap
        p = '{setup: 1, lp: 2, lb: 0, vact: 1, hold: 0, fb: 0, pat: 3, cst: 0};
        run_frames(p, 300, 1, 0);

        // randomized timing and patterns
        for (int it = 0; it < 6; it++) begin
            p.setup = $urandom_range(0, 4); p.lp = $urandom_range(0, 5); p.lb = $urandom_range(0, 3);
            p.vact = $urandom_range(0, 3); p.hold = $urandom_range(0, 3); p.fb = $urandom_range(0, 4);
            p.pat = $urandom_range(0, 3); p.cst = $urandom_range(0, 255);
            run_frames(p, $urandom_range(1, 3), 1, 1);
        end

        // reset during a line aborts at once; the next frame restarts from zero
        drive(basic);
        iENABLE = 1'b1;
        push_idle(1);
        push_frame(basic);
        repeat (3) @(posedge CLK);
        #1;
        sb.delete();
        RST_N = 1'b0;
        #1;
        mf = 0;
        check_zero("reset_mid_line");
        iENABLE = 1'b0;
        @(posedge CLK);
        #1;
        check_zero("reset_held");
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check_zero("idle_after_abort");
        run_frames(basic, 1, cl(basic.setup), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cl_pattern_gen.md
Name: cl_pattern_gen

Overview:
- Camera Link base-configuration source (camera emulator) that drives FVAL/LVAL/DVAL plus two 8-bit taps (DATA_L/DATA_R) with programmable frame timing and test patterns.
- Feeds the Camera Link input path (INP_CAMERA_DATA → CLctrl) for board bring-up and closed-loop verification without a physical camera.
- All outputs registered; the clock doubles as the emitted CCLK.

Parameters:
- PIXEL_WIDTH, 8, bits per tap.
- PARAM_WIDTH, 12, width of every timing input.
- FCNT_WIDTH, 8, width of the frame counter.

Ports:
- CLK  in  1  pixel clock (one pixel pair per cycle).
- RST_N  in  1  asynchronous active-low reset.
- iENABLE  in  1  run request, level-sensitive.
- iPATTERN  in  2  pattern select: 0 h-ramp, 1 v-ramp, 2 constant, 3 moving ramp.
- iCONST  in  PIXEL_WIDTH  value for pattern 2.
- iLINE_PIX  in  PARAM_WIDTH  DVAL cycles per line (pixel pairs).
- iLINE_BLANK  in  PARAM_WIDTH  LVAL-low cycles between lines.
- iVACT  in  PARAM_WIDTH  lines per frame.
- iFV_SETUP  in  PARAM_WIDTH  cycles from FVAL rise to first LVAL.
- iFV_HOLD  in  PARAM_WIDTH  cycles from last LVAL fall to FVAL fall.
- iFRAME_BLANK  in  PARAM_WIDTH  FVAL-low cycles between frames.
- oFVAL  out  1  frame valid.
- oLVAL  out  1  line valid.
- oDVAL  out  1  data valid.
- oDATA_L  out  PIXEL_WIDTH  left (even) tap.
- oDATA_R  out  PIXEL_WIDTH  right (odd) tap.
- oFRAME_DONE  out  1  one-cycle pulse at FVAL fall.
- oFRAME_CNT  out  FCNT_WIDTH  completed-frame count, wraps.
- oBUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset mid-frame aborts immediately, with no trailing LVAL/FVAL.
- States: IDLE, FV_SETUP, LINE, LINE_BLANK, FV_HOLD, FRAME_BLANK.
- IDLE: with iENABLE=1 sampled, oFVAL=1 on the next cycle (state FV_SETUP).
- Parameter latch: all timing inputs and iPATTERN/iCONST are captured on IDLE→FV_SETUP and FRAME_BLANK→FV_SETUP. Changes mid-frame have no effect.
- Clamping: any timing value of 0 is treated as 1.
- FV_SETUP: FVAL=1, LVAL=0; lasts iFV_SETUP cycles, then LINE.
- LINE: FVAL=LVAL=DVAL=1 for iLINE_PIX cycles.
  - If not the last line → LINE_BLANK.
  - If the last line → FV_HOLD.
  - DVAL always equals LVAL; there are no gaps.
- LINE_BLANK: FVAL=1, LVAL=DVAL=0; lasts iLINE_BLANK cycles, then LINE with y+1.
- FV_HOLD: FVAL=1, LVAL=0; lasts iFV_HOLD cycles, then FRAME_BLANK.
- FRAME_BLANK: all valids 0; lasts iFRAME_BLANK cycles.
  - oFRAME_DONE=1 and oFRAME_CNT increments on its first cycle.
  - On exit: iENABLE=1 → FV_SETUP; iENABLE=0 → IDLE.
- iENABLE falling mid-frame: the current frame completes in full, including FRAME_BLANK, then the FSM goes to IDLE.
- Frame period = setup + VACT·LINE_PIX + (VACT−1)·LINE_BLANK + hold + FRAME_BLANK.
- Data: x = pair index in the line (0..LINE_PIX−1), y = line index, f = oFRAME_CNT. Arithmetic is truncated mod 2^PIXEL_WIDTH.
  - pattern 0: L=2x, R=2x+1.
  - pattern 1: L=R=y.
  - pattern 2: L=R=iCONST.
  - pattern 3: L=2x+f, R=2x+1+f.
- Data outside LVAL is 0.
- Data is aligned with DVAL in the same cycle.
- Counter widths: x and y counters are PARAM_WIDTH wide. The frame counter wraps from 2^FCNT_WIDTH−1 to 0.

Decomposition:
- Package cl_pattern_pkg holds:
  - the state encoding;
  - pattern codes PAT_HRAMP=0, PAT_VRAMP=1, PAT_CONST=2, PAT_MOVE=3.
- One sub-module, cl_pattern_data: a registered mapping (pattern, x, y, f, const, active) → (DATA_L, DATA_R), with the same one-cycle alignment as the valids.
- The FSM and timing counters stay in cl_pattern_gen.

Test Plan:
- Basic frame: SETUP=1, LINE_PIX=4, LINE_BLANK=2, VACT=3, HOLD=1, FRAME_BLANK=3, pattern 0, enable held.
  - FVAL high for 18 cycles, low for 3; frame period 21.
  - 3 LVAL pulses of 4 cycles each.
  - Each line carries L=0,2,4,6 and R=1,3,5,7.
  - oFRAME_DONE pulses every 21 cycles.
- Pattern 1, same timing: line 2 carries L=R=2 on all 4 cycles; line 0 carries 0.
- Pattern 3 over 300 frames: first pixel L equals f mod 256; oFRAME_CNT wraps 255→0.
- iENABLE dropped during line 1 of a frame: the frame completes with all 3 lines, oFRAME_DONE pulses, oBUSY=0 after FRAME_BLANK, and no further FVAL.
- All timing inputs 0 with VACT=2: behaves as 1 everywhere, giving FVAL high for 5 cycles and 2 single-cycle LVALs.
- RST_N asserted mid-LINE: all outputs 0 immediately. After release with enable=1, a fresh frame starts at x=0, y=0, FRAME_CNT=0.
